// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter: FSM states, default sizes,
// and one-hot <-> index conversion used by the grant logic.
package led_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_e;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_HOLD_CYCLES = 16;

  function automatic logic [31:0] idx2onehot(input int idx);
    return 32'd1 << idx;
  endfunction

  function automatic int onehot2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int k = 31; k >= 0; k--) begin
      if (oh[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req searching upward from
// (ptr+1) mod N_REQ with wrap-around.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] index
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;
  int                 off;

  // Rotate so bit 0 of rot is the requester just after ptr.
  always_comb begin
    dbl     = {req, req};
    shifted = dbl >> (int'(ptr) + 1);
    rot     = shifted[N_REQ-1:0];
    valid   = 1'b0;
    off     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = k;
      end
    end
    index = IDX_W'((int'(ptr) + 1 + off) % N_REQ);
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing one LED bank between N_REQ requesters, with a
// minimum hold window per grant and a registered LED drive of the owner's data.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         ld
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   ld_q, ld_d;

  logic [N_REQ-1:0]   own_oh;
  logic [N_REQ-1:0]   req_others;
  logic               owner_req;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               grant_new;
  logic               go_idle;
  logic               arb_open;

  // The current owner is masked out so the same picker serves fresh grants,
  // release hand-offs and open-window switches.
  always_comb begin
    own_oh     = busy_q ? N_REQ'(idx2onehot(int'(owner_q))) : '0;
    req_others = req & ~own_oh;
    owner_req  = busy_q && ((req & own_oh) != '0);
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_others),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      ld_q    <= ld_d;
    end
  end

  // An expired hold window is arbitrated in the same cycle as OPEN, so a
  // pending requester takes over exactly HOLD_CYCLES cycles after the grant.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    grant_new = 1'b0;
    go_idle   = 1'b0;
    arb_open  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) grant_new = 1'b1;
      end
      ST_HOLD: begin
        if (!owner_req) begin
          if (pick_valid) grant_new = 1'b1;
          else            go_idle   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          arb_open = 1'b1;
        end
      end
      ST_OPEN: arb_open = 1'b1;
      default: go_idle = 1'b1;
    endcase

    if (arb_open) begin
      if (pick_valid)      grant_new = 1'b1;
      else if (!owner_req) go_idle   = 1'b1;
      else                 state_d   = ST_OPEN;
    end

    if (grant_new) begin
      state_d = ST_HOLD;
      cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      owner_d = pick_idx;
      ptr_d   = pick_idx;
      busy_d  = 1'b1;
    end else if (go_idle) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      owner_d = '0;
      busy_d  = 1'b0;
    end
  end

  always_comb begin
    gnt_d = busy_d ? N_REQ'(idx2onehot(int'(owner_d))) : '0;
    ld_d  = busy_d ? data[int'(owner_d)*WIDTH +: WIDTH] : '0;
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign ld    = ld_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed-vector bench for led_bank_arbiter (N_REQ=4, WIDTH=8, HOLD_CYCLES=4)
// with a queue-based scoreboard checked by an independent monitor.
module tb_led_bank_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] ld;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  ld;

  logic [7:0]  d0, d1, d2, d3;
  exp_t        exp_q[$];
  string       name_q[$];
  int          checks;
  int          errors;
  bit          done;

  led_bank_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .ld    (ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic [1:0] eo, input logic eb, input logic [7:0] eld,
                       input string nm);
    exp_t e;
    rst  = r;
    req  = rq;
    data = {d3, d2, d1, d0};
    e.gnt = eg; e.owner = eo; e.busy = eb; e.ld = eld;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic r, input logic [3:0] rq, input string nm);
    drive(r, rq, 4'b0000, 2'd0, 1'b0, 8'h00, nm);
  endtask

  task automatic own(input logic [3:0] rq, input logic [1:0] idx,
                     input logic [7:0] ldv, input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    drive(1'b0, rq, oh, idx, 1'b1, ldv, nm);
  endtask

  // Monitor: outputs are registered, so every cycle is a presented output.
  initial begin
    exp_t  e;
    string nm;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({gnt, owner, busy, ld} !== e) begin
          errors++;
          $display("FAIL %s: got gnt=%b owner=%0d busy=%b ld=%h, expected gnt=%b owner=%0d busy=%b ld=%h",
                   nm, gnt, owner, busy, ld, e.gnt, e.owner, e.busy, e.ld);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; done = 1'b0;
    rst = 1'b1; req = 4'h0; data = '0;
    d0 = 8'hAA; d1 = 8'h55; d2 = 8'hC9; d3 = 8'h3C;

    // reset with all requests high
    idle(1'b1, 4'hF, "rst_hold_0");
    idle(1'b1, 4'hF, "rst_hold_1");
    idle(1'b0, 4'h0, "after_rst_idle");

    // single requester 1, data change under grant, release
    own(4'b0010, 2'd1, 8'h55, "t2_grant");
    own(4'b0010, 2'd1, 8'h55, "t2_hold1");
    own(4'b0010, 2'd1, 8'h55, "t2_hold2");
    d1 = 8'h66;
    own(4'b0010, 2'd1, 8'h66, "t2_data_follow");
    own(4'b0010, 2'd1, 8'h66, "t2_open");
    own(4'b0010, 2'd1, 8'h66, "t2_open_stay");
    idle(1'b0, 4'b0000, "t2_release");
    idle(1'b0, 4'b0000, "t2_idle_ld0");
    d1 = 8'h55;

    // two requesters from reset
    idle(1'b1, 4'b0000, "t3_rst");
    for (int c = 0; c < 4; c++) own(4'b0101, 2'd0, 8'hAA, "t3_owner0");
    for (int c = 0; c < 4; c++) own(4'b0101, 2'd2, 8'hC9, "t3_owner2");
    idle(1'b0, 4'b0000, "t3_release");

    // all requesting: 0,1,2,3,0 each 4 cycles
    idle(1'b1, 4'b0000, "t4_rst");
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        case (r % 4)
          0: own(4'hF, 2'd0, 8'hAA, "t4_rr0");
          1: own(4'hF, 2'd1, 8'h55, "t4_rr1");
          2: own(4'hF, 2'd2, 8'hC9, "t4_rr2");
          default: own(4'hF, 2'd3, 8'h3C, "t4_rr3");
        endcase
      end
    end
    idle(1'b0, 4'b0000, "t4_release");

    // owner drops early with req3 pending
    idle(1'b1, 4'b0000, "t5_rst");
    own(4'b0010, 2'd1, 8'h55, "t5_grant1");
    own(4'b1010, 2'd1, 8'h55, "t5_no_preempt");
    own(4'b1000, 2'd3, 8'h3C, "t5_handoff3");
    idle(1'b0, 4'b0000, "t5_release");

    // reset in the middle of a hold resets the pointer
    idle(1'b1, 4'b0000, "t6_rst");
    own(4'b0100, 2'd2, 8'hC9, "t6_grant2");
    own(4'b0100, 2'd2, 8'hC9, "t6_hold2");
    idle(1'b1, 4'b0100, "t6_mid_rst");
    own(4'b1001, 2'd0, 8'hAA, "t6_ptr_reset");
    own(4'b1001, 2'd0, 8'hAA, "t6_hold0");
    idle(1'b0, 4'b0000, "t6_release");

    idle(1'b0, 4'b0000, "final_idle");
    @(posedge clk);
    #3;
    done = 1'b1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
